sr_cmd_conditioner: RTL and testbench
=====================================

SR_CMD_CONDITIONER -- requirements
Module: sr_cmd_conditioner

Interface
REQ-001 Parameter DB_CYCLES, default 4, meaning the number of consecutive stable cycles needed to accept a raw level change (legal range 2..255).
REQ-002 Parameter HOLDOFF, default 3, meaning the number of cycles after an issued pulse during which new commands are dropped (legal range 1..255).
REQ-003 Port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 Port reset, input, 1, the reset; it is synchronous and active-low.
REQ-005 Port set_raw, input, 1, asynchronous set request from a button or external logic.
REQ-006 Port clr_raw, input, 1, asynchronous clear request.
REQ-007 Port s, output, 1, one-cycle set pulse that drives the downstream SR flip-flop s input.
REQ-008 Port r, output, 1, one-cycle reset pulse that drives the downstream SR flip-flop r input.
REQ-009 Port q_mirror, output, 1, the expected state of the downstream flip-flop.
REQ-010 Port ready, output, 1, high when the state machine is in IDLE.
REQ-011 Port conflict, output, 1, a one-cycle flag raised when set and clear are accepted in the same cycle.

Function
REQ-012 Each raw input SHALL pass through a 2-flop synchronizer before any other logic sees it.
REQ-013 Each synchronized input SHALL have its own debounce counter and debounced level.
- The counter clears whenever the synchronized value equals the debounced level.
- The counter increments otherwise.
- The debounced level takes the new value on the edge where the counter would reach DB_CYCLES.
REQ-014 A rise of a debounced level SHALL create a one-cycle accept event; falls create no event.
REQ-015 The state machine SHALL have three states: IDLE, PULSE and HOLD.
REQ-016 In IDLE, the following SHALL apply:
- A set-only accept goes to PULSE with s=1 in the next cycle.
- A clear-only accept goes to PULSE with r=1 in the next cycle.
- A simultaneous accept stays in IDLE, issues no pulse and sets conflict=1 for the next cycle.
REQ-017 PULSE SHALL last exactly one cycle and then go to HOLD.
REQ-018 HOLD SHALL last exactly HOLDOFF cycles and then return to IDLE; accept events in PULSE or HOLD are discarded, not queued.
REQ-019 s and r SHALL be registered outputs and SHALL never both be 1 in the same cycle.
REQ-020 q_mirror SHALL go to 1 in the same cycle s=1, go to 0 in the same cycle r=1, and hold otherwise.
REQ-021 Latency from a raw rising level to the s or r pulse SHALL be exactly DB_CYCLES+3 rising edges, counted from the first edge that samples the new level, when the state machine is in IDLE.
REQ-022 A raw glitch shorter than DB_CYCLES synchronized cycles SHALL produce no event.
REQ-023 A raw input held high SHALL produce only one pulse.

Reset
REQ-024 When reset is low at a rising edge, the following SHALL apply:
- The synchronizers, counters and debounced levels clear to 0.
- The state machine goes to IDLE.
- s, r, q_mirror and conflict become 0, and ready becomes 1.
REQ-025 If reset is asserted in the middle of PULSE or HOLD, the operation SHALL be aborted with no further pulse.
REQ-026 After reset is released, raw inputs that are already high SHALL be debounced as new rises.

Configuration
REQ-027 When SR_COND_CONFLICT_CNT_EN is defined, the block SHALL add an 8-bit output conflict_cnt.
- It increments on each conflict and saturates at 255.
- It clears on reset.
REQ-028 When SR_COND_CONFLICT_CNT_EN is undefined, the port and counter SHALL be absent; all other behaviour is identical.

Verification (DB_CYCLES=4, HOLDOFF=3)
REQ-029 Raise set_raw after reset and hold it -> s=1 for exactly one cycle, 7 edges after the first sampling edge; q_mirror=1 from then; ready low for 4 cycles.
REQ-030 With q_mirror=1, raise clr_raw -> r=1 for one cycle after 7 edges; q_mirror=0.
REQ-031 Raise set_raw and clr_raw on the same edge -> no s and no r; conflict=1 for one cycle; conflict_cnt=1 if enabled.
REQ-032 Apply a 3-cycle set_raw glitch, then a clean set_raw -> no pulse for the glitch and one s pulse for the clean rise.
REQ-033 Cause clr_raw to be accepted during HOLD after an s pulse -> the clear is dropped; r stays 0; q_mirror stays 1.
REQ-034 Assert reset while the state machine is in HOLD with set_raw high -> all outputs go to their reset values; after release, s pulses again 7 edges later.

Source files
------------

// File: rtl/sr_cmd_conditioner.sv
// ---------------------------------------------------------------------------
// sr_cmd_conditioner
//
// Turns two noisy asynchronous requests (set_raw / clr_raw) into clean,
// mutually exclusive one-cycle s / r pulses for a downstream SR flip-flop.
// Each input is synchronized, then debounced. Only a rising debounced
// level becomes a command. A small IDLE -> PULSE -> HOLD state machine
// issues one pulse and then ignores further commands for HOLDOFF cycles.
//
// Parameters:
//   DB_CYCLES  consecutive stable cycles needed to accept a change (2..255)
//   HOLDOFF    cycles after a pulse during which commands are dropped (1..255)
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-low reset
//   set_raw       asynchronous set request
//   clr_raw       asynchronous clear request
//   s             one-cycle set pulse (registered)
//   r             one-cycle reset pulse (registered)
//   q_mirror      expected state of the downstream flip-flop
//   ready         high while the state machine is in IDLE
//   conflict      one-cycle flag: set and clear were accepted together
//   conflict_cnt  saturating 8-bit conflict count. Present only when
//                 SR_COND_CONFLICT_CNT_EN is defined.
// ---------------------------------------------------------------------------
module sr_cmd_conditioner #(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned HOLDOFF   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       set_raw,
    input  logic       clr_raw,
    output logic       s,
    output logic       r,
    output logic       q_mirror,
    output logic       ready,
    output logic       conflict
`ifdef SR_COND_CONFLICT_CNT_EN
    ,
    output logic [7:0] conflict_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam logic [7:0] DB_LAST   = 8'(DB_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF - 1);

    // Channel 0 is set and channel 1 is clear.
    logic [1:0] sync1_q, sync2_q;
    logic [1:0] level_q, level_d;
    logic [1:0] level_prev_q;
    logic [7:0] db_cnt_q [2];
    logic [7:0] db_cnt_d [2];
    logic [1:0] accept;

    state_e     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       s_q, s_d;
    logic       r_q, r_d;
    logic       q_q, q_d;
    logic       conf_q, conf_d;

    // Debounce: count cycles where the synchronized value differs from the
    // accepted level. A match resets the count. The level flips on the edge
    // where the count would reach DB_CYCLES.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            // NOTE: every always_comb output gets a default first so no path
            // leaves it unassigned; otherwise a latch would be inferred.
            level_d[ch]  = level_q[ch];
            db_cnt_d[ch] = db_cnt_q[ch];
            if (sync2_q[ch] == level_q[ch]) begin
                db_cnt_d[ch] = 8'd0;
            end else if (db_cnt_q[ch] == DB_LAST) begin
                level_d[ch]  = sync2_q[ch];
                db_cnt_d[ch] = 8'd0;
            end else begin
                db_cnt_d[ch] = db_cnt_q[ch] + 8'd1;
            end
        end
    end

    // A command is a rising debounced level. The pulse lasts exactly one cycle.
    assign accept = level_q & ~level_prev_q;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge inputs, whatever the statement order.
        if (!reset) begin
            sync1_q      <= 2'b00;
            sync2_q      <= 2'b00;
            level_q      <= 2'b00;
            level_prev_q <= 2'b00;
            db_cnt_q[0]  <= 8'd0;
            db_cnt_q[1]  <= 8'd0;
        end else begin
            sync1_q      <= {clr_raw, set_raw};
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            db_cnt_q[0]  <= db_cnt_d[0];
            db_cnt_q[1]  <= db_cnt_d[1];
        end
    end

    // Next-state and registered-output logic. Commands that arrive outside
    // IDLE are ignored. They are not queued.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        s_d     = 1'b0;
        r_d     = 1'b0;
        q_d     = q_q;
        conf_d  = 1'b0;
        case (state_q)
            IDLE: begin
                case (accept)
                    2'b11: conf_d = 1'b1;
                    2'b01: begin
                        s_d     = 1'b1;
                        q_d     = 1'b1;
                        state_d = PULSE;
                    end
                    2'b10: begin
                        r_d     = 1'b1;
                        q_d     = 1'b0;
                        state_d = PULSE;
                    end
                    default: ;
                endcase
            end
            PULSE: begin
                state_d = HOLD;
                hold_d  = HOLD_LAST;
            end
            HOLD: begin
                // hold counts down from HOLDOFF-1 to 0, which gives HOLDOFF cycles.
                if (hold_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            hold_q  <= 8'd0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            q_q     <= 1'b0;
            conf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            s_q     <= s_d;
            r_q     <= r_d;
            q_q     <= q_d;
            conf_q  <= conf_d;
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign q_mirror = q_q;
    assign conflict = conf_q;
    assign ready    = (state_q == IDLE);

`ifdef SR_COND_CONFLICT_CNT_EN
    logic [7:0] conf_cnt_q;

    // Counts at the same edge that raises conflict. Stops at 255.
    always_ff @(posedge clk) begin
        if (!reset) begin
            conf_cnt_q <= 8'd0;
        end else if (conf_d && (conf_cnt_q != 8'hFF)) begin
            conf_cnt_q <= conf_cnt_q + 8'd1;
        end
    end

    assign conflict_cnt = conf_cnt_q;
`endif

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// ---------------------------------------------------------------------------
// tb_sr_cmd_conditioner
//
// Self-checking bench for sr_cmd_conditioner (DB_CYCLES=4, HOLDOFF=3).
// Directed scenarios run first, then a randomized phase. A behavioural
// reference model predicts every output on every cycle:
//   - the raw level reaches the debouncer two edges after it is sampled
//   - the level is accepted after DB stable differing samples
//   - a rising level is a command for the next edge
//   - after a pulse the block is busy for 1+HOLDOFF edges
// Define SR_COND_CONFLICT_CNT_EN for the bench as well as the RTL to check
// conflict_cnt.
// ---------------------------------------------------------------------------
module tb_sr_cmd_conditioner;

    localparam int DB = 4;
    localparam int HO = 3;
    localparam int LAT = DB + 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic set_raw = 1'b0;
    logic clr_raw = 1'b0;
    logic s, r, q_mirror, ready, conflict;
`ifdef SR_COND_CONFLICT_CNT_EN
    logic [7:0] conflict_cnt;
`endif

    sr_cmd_conditioner #(.DB_CYCLES(DB), .HOLDOFF(HO)) dut (
        .clk      (clk),
        .reset    (reset),
        .set_raw  (set_raw),
        .clr_raw  (clr_raw),
        .s        (s),
        .r        (r),
        .q_mirror (q_mirror),
        .ready    (ready),
        .conflict (conflict)
`ifdef SR_COND_CONFLICT_CNT_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state
    bit m_d1 [2];      // raw sampled one edge ago
    bit m_d2 [2];      // raw sampled two edges ago
    bit m_level [2];
    int m_run [2];
    bit m_rose [2];
    int m_busy;
    bit exp_s, exp_r, exp_q, exp_conf;
    int exp_cc;

    int chk = 0;
    int passed = 0;
    int failed = 0;
    int s_seen, r_seen, conf_seen, ready_low_seen;
    int n;

    task automatic check(input string tag, input int obs, input int exp);
        chk++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one rising edge, using the inputs sampled there.
    task automatic model_edge();
        bit acc_s, acc_c;
        bit raw [2];
        acc_s = m_rose[0];
        acc_c = m_rose[1];
        raw[0] = set_raw;
        raw[1] = clr_raw;
        if (!reset) begin
            for (int ch = 0; ch < 2; ch++) begin
                m_d1[ch] = 0; m_d2[ch] = 0; m_level[ch] = 0;
                m_run[ch] = 0; m_rose[ch] = 0;
            end
            m_busy = 0;
            exp_s = 0; exp_r = 0; exp_q = 0; exp_conf = 0; exp_cc = 0;
            return;
        end
        exp_s = 0; exp_r = 0; exp_conf = 0;
        if (m_busy == 0) begin
            if (acc_s && acc_c) begin
                exp_conf = 1;
                if (exp_cc < 255) exp_cc++;
            end else if (acc_s) begin
                exp_s = 1; exp_q = 1; m_busy = 1 + HO;
            end else if (acc_c) begin
                exp_r = 1; exp_q = 0; m_busy = 1 + HO;
            end
        end else begin
            m_busy--;
        end
        for (int ch = 0; ch < 2; ch++) begin
            m_rose[ch] = 0;
            if (m_d2[ch] != m_level[ch]) begin
                m_run[ch]++;
                if (m_run[ch] == DB) begin
                    m_level[ch] = m_d2[ch];
                    m_run[ch] = 0;
                    m_rose[ch] = m_level[ch];
                end
            end else begin
                m_run[ch] = 0;
            end
            m_d2[ch] = m_d1[ch];
            m_d1[ch] = raw[ch];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("s", int'(s), int'(exp_s));
        check("r", int'(r), int'(exp_r));
        check("q_mirror", int'(q_mirror), int'(exp_q));
        check("ready", int'(ready), int'(m_busy == 0));
        check("conflict", int'(conflict), int'(exp_conf));
        check("s_r_exclusive", int'(s & r), 0);
`ifdef SR_COND_CONFLICT_CNT_EN
        check("conflict_cnt", int'(conflict_cnt), exp_cc);
`endif
        s_seen += int'(s === 1'b1);
        r_seen += int'(r === 1'b1);
        conf_seen += int'(conflict === 1'b1);
        ready_low_seen += int'(ready === 1'b0);
    endtask

    // Tick until the selected pulse appears, up to a bounded number of edges.
    task automatic run_until(input bit want_r, output int edges);
        edges = 0;
        do begin
            tick();
            edges++;
        end while (!((want_r ? r : s) === 1'b1) && edges < 40);
    endtask

    task automatic clear_seen();
        s_seen = 0; r_seen = 0; conf_seen = 0; ready_low_seen = 0;
    endtask

    initial begin
        clear_seen();
        // Reset
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();

        // Set held high: one s pulse after LAT edges, ready low for 1+HO cycles
        clear_seen();
        set_raw = 1'b1;
        run_until(1'b0, n);
        check("set_latency", n, LAT);
        repeat (10) tick();
        check("set_single_pulse", s_seen, 1);
        check("ready_low_cycles", ready_low_seen, 1 + HO);

        // Clear while q_mirror=1
        clear_seen();
        clr_raw = 1'b1;
        run_until(1'b1, n);
        check("clr_latency", n, LAT);
        check("q_after_clr", int'(q_mirror), 0);
        set_raw = 1'b0; clr_raw = 1'b0;
        repeat (12) tick();

        // Simultaneous set and clear give a conflict and no pulse
        clear_seen();
        set_raw = 1'b1; clr_raw = 1'b1;
        repeat (14) tick();
        check("conflict_once", conf_seen, 1);
        check("conflict_no_s", s_seen, 0);
        check("conflict_no_r", r_seen, 0);
        set_raw = 1'b0; clr_raw = 1'b0;
        repeat (12) tick();

        // A 3-cycle glitch is ignored. A clean rise that follows is accepted.
        clear_seen();
        set_raw = 1'b1;
        repeat (3) tick();
        set_raw = 1'b0;
        repeat (10) tick();
        check("glitch_no_pulse", s_seen, 0);
        set_raw = 1'b1;
        run_until(1'b0, n);
        check("clean_after_glitch_latency", n, LAT);

        // A clear accepted during HOLD is dropped
        set_raw = 1'b0;
        repeat (12) tick();
        clear_seen();
        set_raw = 1'b1;
        repeat (3) tick();
        clr_raw = 1'b1;
        repeat (15) tick();
        check("hold_s_pulses", s_seen, 1);
        check("hold_clr_dropped", r_seen, 0);
        check("hold_q_kept", int'(q_mirror), 1);
        set_raw = 1'b0; clr_raw = 1'b0;
        repeat (12) tick();

        // Reset in HOLD with set_raw high, then a fresh pulse after release
        set_raw = 1'b1;
        run_until(1'b0, n);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        clear_seen();
        run_until(1'b0, n);
        check("post_reset_latency", n, LAT);
        repeat (10) tick();
        check("post_reset_single", s_seen, 1);

        // Randomized phase
        repeat (60) begin
            set_raw = 1'($urandom_range(0, 1));
            clr_raw = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 24) != 0);
            repeat ($urandom_range(1, 10)) tick();
        end
        reset = 1'b1;
        set_raw = 1'b0; clr_raw = 1'b0;
        repeat (15) tick();

        $display("%0d/%0d checks passed", passed, chk);
        $finish;
    end

endmodule
